// File: rtl/reg_bank_alloc.sv
// Register bank of the DAG processor: lowest-free-slot allocation,
// 1-cycle reads, and slot release on invalidate.
module reg_bank_alloc #(
    parameter int WORD_L = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_L = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_L-1:0] wr_data,
    output logic [ADDR_L-1:0] alloc_addr,
    output logic              wr_err,
    input  logic              rd_en,
    input  logic [ADDR_L-1:0] rd_addr,
    output logic [WORD_L-1:0] rd_data,
    output logic              rd_vld,
    input  logic              inv_en,
    input  logic [ADDR_L-1:0] inv_addr,
    output logic              inv_err,
    output logic [ADDR_L:0]   n_free,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_L:0] N_ALL = (ADDR_L+1)'(DEPTH);

    logic [WORD_L-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              wr_ok;
    logic              inv_ok;

    assign full   = (n_free == '0);
    assign empty  = (n_free == N_ALL);
    assign wr_ok  = wr_en & ~full;
    assign inv_ok = inv_en & valid[inv_addr];

    // Scan downward so the lowest free index wins.
    always_comb begin
        alloc_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_addr = ADDR_L'(i);
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[alloc_addr] <= wr_data;
        end
    end

    // A freed slot is never the alloc target in the same cycle because
    // alloc_addr is derived from the registered bitmap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (wr_ok) begin
                valid[alloc_addr] <= 1'b1;
            end
            if (inv_ok) begin
                valid[inv_addr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_free <= N_ALL;
        end else begin
            unique case ({inv_ok, wr_ok})
                2'b10:   n_free <= n_free + 1'b1;
                2'b01:   n_free <= n_free - 1'b1;
                default: n_free <= n_free;
            endcase
        end
    end

    // Reads sample pre-edge contents: read-before-write, read-and-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_vld  <= valid[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err  <= 1'b0;
            inv_err <= 1'b0;
        end else begin
            wr_err  <= wr_en & full;
            inv_err <= inv_en & ~valid[inv_addr];
        end
    end

    a_nfree_popcount: assert property (
        @(posedge clk) disable iff (rst)
        n_free == N_ALL - (ADDR_L+1)'($countones(valid))
    );

endmodule

// File: tb/tb_reg_bank_alloc.sv
// Randomized and directed bench for reg_bank_alloc against a
// slot-array reference model.
module tb_reg_bank_alloc;

    localparam int W = 32;
    localparam int D = 256;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [A-1:0] alloc_addr;
    logic         wr_err;
    logic         rd_en = 1'b0;
    logic [A-1:0] rd_addr = '0;
    logic [W-1:0] rd_data;
    logic         rd_vld;
    logic         inv_en = 1'b0;
    logic [A-1:0] inv_addr = '0;
    logic         inv_err;
    logic [A:0]   n_free;
    logic         full;
    logic         empty;

    always #5 clk = ~clk;

    reg_bank_alloc #(.WORD_L(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .alloc_addr(alloc_addr),
        .wr_err(wr_err),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_vld(rd_vld),
        .inv_en(inv_en),
        .inv_addr(inv_addr),
        .inv_err(inv_err),
        .n_free(n_free),
        .full(full),
        .empty(empty)
    );

    logic [W-1:0] mm [D];
    bit           mv [D];
    bit           mk [D];
    logic [W-1:0] e_rd_data;
    bit           e_rd_known;
    bit           e_rd_vld;
    bit           e_wr_err;
    bit           e_inv_err;
    int           total = 0;
    int           bad = 0;

    function automatic int low_free();
        for (int i = 0; i < D; i++) begin
            if (!mv[i]) return i;
        end
        return 0;
    endfunction

    function automatic int cnt_free();
        int c = 0;
        for (int i = 0; i < D; i++) begin
            if (!mv[i]) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) mv[i] = 1'b0;
        e_rd_data  = '0;
        e_rd_known = 1'b1;
        e_rd_vld   = 1'b0;
        e_wr_err   = 1'b0;
        e_inv_err  = 1'b0;
    endtask

    // Drive one cycle and advance the model across the same edge.
    task automatic cyc(input bit we, input logic [W-1:0] wd,
                       input bit re, input logic [A-1:0] ra,
                       input bit ie, input logic [A-1:0] ia);
        int a;
        bit fl;
        bit wok;
        bit iok;
        wr_en = we; wr_data = wd;
        rd_en = re; rd_addr = ra;
        inv_en = ie; inv_addr = ia;
        a   = low_free();
        fl  = (cnt_free() == 0);
        wok = we && !fl;
        iok = ie && mv[ia];
        if (re) begin
            e_rd_data  = mm[ra];
            e_rd_known = mk[ra];
            e_rd_vld   = mv[ra];
        end
        e_wr_err  = we && fl;
        e_inv_err = ie && !mv[ia];
        if (wok) begin
            mm[a] = wd;
            mv[a] = 1'b1;
            mk[a] = 1'b1;
        end
        if (iok) mv[ia] = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        inv_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < D; i++) mk[i] = 1'b0;
        model_reset();
        rst = 1'b1;
        #12;
        total++;
        if (n_free !== 9'd256 || empty !== 1'b1 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_cnt: n_free=%0d empty=%b full=%b want 256/1/0",
                     n_free, empty, full);
        end
        total++;
        if (alloc_addr !== 8'd0 || rd_vld !== 1'b0 || rd_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_out: alloc=%0d rd_vld=%b rd_data=%h want 0/0/0",
                     alloc_addr, rd_vld, rd_data);
        end
        total++;
        if (wr_err !== 1'b0 || inv_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: wr_err=%b inv_err=%b want 0/0",
                     wr_err, inv_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (alloc_addr !== 8'(i)) begin
                bad++;
                $display("FAIL wr_alloc%0d: alloc=%0d want %0d", i, alloc_addr, i);
            end
            cyc(1'b1, 32'hA + 32'(i), 1'b0, '0, 1'b0, '0);
        end
        total++;
        if (n_free !== 9'd253 || empty !== 1'b0) begin
            bad++;
            $display("FAIL wr_nfree: n_free=%0d empty=%b want 253/0", n_free, empty);
        end
        cyc(1'b0, '0, 1'b1, 8'd1, 1'b0, '0);
        total++;
        if (rd_data !== 32'hB || rd_vld !== 1'b1) begin
            bad++;
            $display("FAIL rd_addr1: rd_data=%h rd_vld=%b want b/1", rd_data, rd_vld);
        end
    endtask

    task automatic test_inv_write_same();
        total++;
        if (alloc_addr !== 8'd3) begin
            bad++;
            $display("FAIL iw_pre_alloc: alloc=%0d want 3", alloc_addr);
        end
        cyc(1'b1, 32'hD, 1'b0, '0, 1'b1, 8'd1);
        total++;
        if (alloc_addr !== 8'd1 || n_free !== 9'd253) begin
            bad++;
            $display("FAIL iw_post: alloc=%0d n_free=%0d want 1/253",
                     alloc_addr, n_free);
        end
        cyc(1'b0, '0, 1'b1, 8'd3, 1'b0, '0);
        total++;
        if (rd_data !== 32'hD || rd_vld !== 1'b1) begin
            bad++;
            $display("FAIL iw_slot3: rd_data=%h rd_vld=%b want d/1", rd_data, rd_vld);
        end
    endtask

    task automatic test_full();
        int n;
        n = cnt_free();
        repeat (n) cyc(1'b1, 32'(low_free()) * 32'h11, 1'b0, '0, 1'b0, '0);
        total++;
        if (full !== 1'b1 || n_free !== 9'd0 || empty !== 1'b0) begin
            bad++;
            $display("FAIL full_set: full=%b n_free=%0d empty=%b want 1/0/0",
                     full, n_free, empty);
        end
        cyc(1'b1, 32'hDEAD, 1'b0, '0, 1'b0, '0);
        total++;
        if (wr_err !== 1'b1 || n_free !== 9'd0) begin
            bad++;
            $display("FAIL full_drop: wr_err=%b n_free=%0d want 1/0", wr_err, n_free);
        end
        cyc(1'b0, '0, 1'b1, 8'd0, 1'b0, '0);
        total++;
        if (wr_err !== 1'b0 || rd_data !== 32'hA) begin
            bad++;
            $display("FAIL full_pulse: wr_err=%b rd_data=%h want 0/a", wr_err, rd_data);
        end
        cyc(1'b0, '0, 1'b1, 8'd255, 1'b0, '0);
        total++;
        if (rd_data !== 32'h10EF || rd_vld !== 1'b1) begin
            bad++;
            $display("FAIL full_last: rd_data=%h rd_vld=%b want 10ef/1",
                     rd_data, rd_vld);
        end
    endtask

    task automatic test_read_inv();
        cyc(1'b0, '0, 1'b1, 8'd5, 1'b1, 8'd5);
        total++;
        if (rd_data !== 32'h55 || rd_vld !== 1'b1 || n_free !== 9'd1) begin
            bad++;
            $display("FAIL ri_same: rd_data=%h rd_vld=%b n_free=%0d want 55/1/1",
                     rd_data, rd_vld, n_free);
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 8'd5);
        total++;
        if (inv_err !== 1'b1 || n_free !== 9'd1) begin
            bad++;
            $display("FAIL ri_double: inv_err=%b n_free=%0d want 1/1", inv_err, n_free);
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b0, '0);
        total++;
        if (inv_err !== 1'b0 || alloc_addr !== 8'd5) begin
            bad++;
            $display("FAIL ri_after: inv_err=%b alloc=%0d want 0/5", inv_err, alloc_addr);
        end
    endtask

    task automatic test_random();
        int wp;
        int ip;
        logic [A-1:0] ia;
        for (int ch = 0; ch < 8; ch++) begin
            wp = (ch % 2 == 0) ? 85 : 25;
            ip = (ch % 2 == 0) ? 20 : 75;
            for (int k = 0; k < 300; k++) begin
                ia = (ch % 4 == 3) ? 8'($urandom_range(31)) : 8'($urandom_range(255));
                cyc($urandom_range(99) < wp, $urandom,
                    $urandom_range(1) == 1, 8'($urandom_range(255)),
                    $urandom_range(99) < ip, ia);
                total++;
                if (alloc_addr !== 8'(low_free()) || n_free !== 9'(cnt_free())) begin
                    bad++;
                    $display("FAIL rnd_alloc: alloc=%0d n_free=%0d want %0d/%0d",
                             alloc_addr, n_free, low_free(), cnt_free());
                end
                total++;
                if (full !== (cnt_free() == 0) || empty !== (cnt_free() == D)) begin
                    bad++;
                    $display("FAIL rnd_flags: full=%b empty=%b free=%0d",
                             full, empty, cnt_free());
                end
                total++;
                if (wr_err !== e_wr_err || inv_err !== e_inv_err) begin
                    bad++;
                    $display("FAIL rnd_err: wr_err=%b inv_err=%b want %b/%b",
                             wr_err, inv_err, e_wr_err, e_inv_err);
                end
                total++;
                if (rd_vld !== e_rd_vld || (e_rd_known && rd_data !== e_rd_data)) begin
                    bad++;
                    $display("FAIL rnd_read: rd_vld=%b rd_data=%h want %b/%h",
                             rd_vld, rd_data, e_rd_vld, e_rd_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, '0, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 8'd4, 1'b0, '0);
        total++;
        if (rd_vld !== 1'b1 || rd_data !== 32'h104 || n_free !== 9'd246) begin
            bad++;
            $display("FAIL rm_pre: rd_vld=%b rd_data=%h n_free=%0d want 1/104/246",
                     rd_vld, rd_data, n_free);
        end
        rd_en = 1'b1;
        rd_addr = 8'd2;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rd_vld !== 1'b0 || rd_data !== 32'd0 || n_free !== 9'd256) begin
            bad++;
            $display("FAIL rm_async: rd_vld=%b rd_data=%h n_free=%0d want 0/0/256",
                     rd_vld, rd_data, n_free);
        end
        total++;
        if (alloc_addr !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
            bad++;
            $display("FAIL rm_flags: alloc=%0d empty=%b full=%b want 0/1/0",
                     alloc_addr, empty, full);
        end
        @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (alloc_addr !== 8'd0 || n_free !== 9'd256 || rd_vld !== 1'b0) begin
            bad++;
            $display("FAIL rm_release: alloc=%0d n_free=%0d rd_vld=%b want 0/256/0",
                     alloc_addr, n_free, rd_vld);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_inv_write_same();
        test_full();
        test_read_inv();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
